// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave address matcher.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BYTE1    = 3'd1,
    HDR_ACK  = 3'd2,
    BYTE2    = 3'd3,
    MATCHED  = 3'd4,
    NOMATCH  = 3'd5
  } addr_state_t;

  localparam logic [6:0] GEN_CALL_ADDR  = 7'h00;
  localparam logic [4:0] TENBIT_PREFIX  = 5'b11110;
  localparam int         MAX_ADDR_SLOTS = 8;

  // Index of the lowest set bit; 0 when none is set.
  function automatic logic [2:0] lowest_set(input logic [MAX_ADDR_SLOTS-1:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = MAX_ADDR_SLOTS - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/counter.sv
// Generic up-counter with synchronous clear (priority) and count enable.
module counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_r;

  // Count register: clear wins over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {WIDTH{1'b0}};
    end else if (clr) begin
      count_r <= {WIDTH{1'b0}};
    end else if (en) begin
      count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign count = count_r;

endmodule

// File: rtl/i2c_addr_match.sv
// Multi-slot I2C slave address matcher: 7-bit, 10-bit (write and repeated-start
// read headers) and optional general call, decoded from the serial address phase.
module i2c_addr_match
  import i2c_pkg::*;
#(
  parameter int NUM_ADDR    = 2,
  parameter int GEN_CALL_EN = 1
) (
  input  logic                                              FPGA_clk,
  input  logic                                              rst,
  input  logic                                              SCL,
  input  logic                                              SCL_prev,
  input  logic                                              SDA,
  input  logic                                              enable,
  input  logic [NUM_ADDR*10-1:0]                            addr_table,
  input  logic [NUM_ADDR-1:0]                               addr_is10,
  output logic                                              hdr_ack,
  output logic                                              done,
  output logic                                              selected,
  output logic                                              rw,
  output logic                                              gen_call,
  output logic                                              is_10bit,
  output logic [((NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1)-1:0] match_idx
);

  localparam int IDX_W    = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1;
  localparam int NSLOT_P2 = 1 << IDX_W;

  addr_state_t      state_r;
  logic [6:0]       shift_r;
  logic [1:0]       hdr_hi_r;
  logic             last10_valid_r;
  logic [IDX_W-1:0] last_idx_r;
  logic             done_r;
  logic             hdr_ack_r;
  logic             selected_r;
  logic             rw_r;
  logic             gen_call_r;
  logic             is_10bit_r;
  logic [IDX_W-1:0] match_idx_r;

  logic             rise_s;
  logic [7:0]       byte_s;
  logic [3:0]       cnt_s;
  logic             cnt_clr_s;
  logic             cnt_en_s;
  logic             last_bit_s;
  logic [NUM_ADDR-1:0] hit7_s;
  logic [NUM_ADDR-1:0] hdr_hit_s;
  logic [NUM_ADDR-1:0] hit10_s;
  logic [1:0]       slot_hi_s [NSLOT_P2];
  logic [IDX_W-1:0] idx7_s;
  logic [IDX_W-1:0] idx10_s;
  logic             gc_s;
  logic             pfx_s;
  logic             reserved_s;
  logic             rd_hit_s;

  assign rise_s     = SCL & ~SCL_prev;
  // Byte as it will look once the current bit is shifted in.
  assign byte_s     = {shift_r, SDA};
  assign last_bit_s = rise_s && (cnt_s == 4'd7);

  counter #(.WIDTH(4)) u_bit_cnt (
    .clk   (FPGA_clk),
    .rst_n (rst),
    .clr   (cnt_clr_s),
    .en    (cnt_en_s),
    .count (cnt_s)
  );

  // Slot table padded to a power of two so the stored index never overruns.
  for (genvar k = 0; k < NSLOT_P2; k++) begin : g_slot
    if (k < NUM_ADDR) begin : g_real
      assign hit7_s[k]    = !addr_is10[k] && (addr_table[10*k +: 7] == byte_s[7:1]);
      assign hdr_hit_s[k] = addr_is10[k] && (addr_table[10*k+8 +: 2] == byte_s[2:1]);
      assign hit10_s[k]   = addr_is10[k] && (addr_table[10*k +: 10] == {hdr_hi_r, byte_s});
      assign slot_hi_s[k] = addr_table[10*k+8 +: 2];
    end else begin : g_pad
      assign slot_hi_s[k] = 2'b00;
    end
  end

  assign idx7_s     = IDX_W'(lowest_set(MAX_ADDR_SLOTS'(hit7_s)));
  assign idx10_s    = IDX_W'(lowest_set(MAX_ADDR_SLOTS'(hit10_s)));
  assign gc_s       = (GEN_CALL_EN != 0) && (byte_s[7:1] == GEN_CALL_ADDR) && !byte_s[0];
  assign pfx_s      = (byte_s[7:3] == TENBIT_PREFIX);
  assign reserved_s = (byte_s[7:4] == 4'b0000) || (byte_s[7:4] == 4'b1111);
  assign rd_hit_s   = pfx_s && byte_s[0] && last10_valid_r &&
                      (slot_hi_s[last_idx_r] == byte_s[2:1]);

  // Bit counter control: counts rises inside a byte, clears on every state entry.
  always_comb begin
    cnt_clr_s = 1'b1;
    cnt_en_s  = 1'b0;
    if (!enable) begin
      cnt_clr_s = 1'b1;
      cnt_en_s  = 1'b0;
    end else begin
      case (state_r)
        BYTE1, BYTE2: begin
          cnt_en_s  = rise_s;
          cnt_clr_s = last_bit_s;
        end
        HDR_ACK: begin
          cnt_en_s  = 1'b0;
          cnt_clr_s = rise_s;
        end
        default: begin
          cnt_en_s  = 1'b0;
          cnt_clr_s = 1'b1;
        end
      endcase
    end
  end

  // Address-phase FSM with registered result outputs.
  always_ff @(posedge FPGA_clk or negedge rst) begin
    if (!rst) begin
      state_r        <= IDLE;
      shift_r        <= 7'd0;
      hdr_hi_r       <= 2'b00;
      last10_valid_r <= 1'b0;
      last_idx_r     <= {IDX_W{1'b0}};
      done_r         <= 1'b0;
      hdr_ack_r      <= 1'b0;
      selected_r     <= 1'b0;
      rw_r           <= 1'b0;
      gen_call_r     <= 1'b0;
      is_10bit_r     <= 1'b0;
      match_idx_r    <= {IDX_W{1'b0}};
    end else begin
      done_r    <= 1'b0;
      hdr_ack_r <= 1'b0;
      if (!enable) begin
        // Abort or normal end of frame; a late final bit never produces done.
        state_r     <= IDLE;
        shift_r     <= 7'd0;
        selected_r  <= 1'b0;
        rw_r        <= 1'b0;
        gen_call_r  <= 1'b0;
        is_10bit_r  <= 1'b0;
        match_idx_r <= {IDX_W{1'b0}};
      end else begin
        case (state_r)
          IDLE: begin
            state_r <= BYTE1;
            shift_r <= 7'd0;
          end
          BYTE1: begin
            if (rise_s) shift_r <= byte_s[6:0];
            if (last_bit_s) begin
              hdr_hi_r <= byte_s[2:1];
              if (gc_s) begin
                state_r     <= MATCHED;
                done_r      <= 1'b1;
                selected_r  <= 1'b1;
                gen_call_r  <= 1'b1;
                match_idx_r <= {IDX_W{1'b0}};
              end else if (pfx_s && !byte_s[0] && (|hdr_hit_s)) begin
                state_r   <= HDR_ACK;
                hdr_ack_r <= 1'b1;
              end else if (rd_hit_s) begin
                state_r     <= MATCHED;
                done_r      <= 1'b1;
                selected_r  <= 1'b1;
                rw_r        <= 1'b1;
                is_10bit_r  <= 1'b1;
                match_idx_r <= last_idx_r;
              end else if (!reserved_s && (|hit7_s)) begin
                state_r        <= MATCHED;
                done_r         <= 1'b1;
                selected_r     <= 1'b1;
                rw_r           <= byte_s[0];
                match_idx_r    <= idx7_s;
                last10_valid_r <= 1'b0;
              end else begin
                state_r        <= NOMATCH;
                done_r         <= 1'b1;
                last10_valid_r <= 1'b0;
              end
            end
          end
          HDR_ACK: begin
            if (rise_s) state_r <= BYTE2;
          end
          BYTE2: begin
            if (rise_s) shift_r <= byte_s[6:0];
            if (last_bit_s) begin
              done_r <= 1'b1;
              if (|hit10_s) begin
                state_r        <= MATCHED;
                selected_r     <= 1'b1;
                rw_r           <= 1'b0;
                is_10bit_r     <= 1'b1;
                match_idx_r    <= idx10_s;
                last10_valid_r <= 1'b1;
                last_idx_r     <= idx10_s;
              end else begin
                state_r        <= NOMATCH;
                last10_valid_r <= 1'b0;
              end
            end
          end
          MATCHED, NOMATCH: begin
            state_r <= state_r;
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  assign hdr_ack   = hdr_ack_r;
  assign done      = done_r;
  assign selected  = selected_r;
  assign rw        = rw_r;
  assign gen_call  = gen_call_r;
  assign is_10bit  = is_10bit_r;
  assign match_idx = match_idx_r;

endmodule

// File: tb/tb_i2c_addr_match.sv
// Scoreboard bench for i2c_addr_match: two instances (general call on/off)
// share stimulus; expected results are queued per frame and checked on done.
module tb_i2c_addr_match;

  typedef struct packed {
    logic       sel;
    logic       rw;
    logic       gc;
    logic       t10;
    logic [0:0] idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scl;
  logic        scl_prev;
  logic        sda;
  logic        en;
  logic [19:0] tbl;
  logic [1:0]  is10;

  logic hdr_m, done_m, sel_m, rw_m, gc_m, t10_m;
  logic [0:0] idx_m;
  logic hdr_n, done_n, sel_n, rw_n, gc_n, t10_n;
  logic [0:0] idx_n;

  exp_t q_m[$];
  exp_t q_n[$];
  exp_t e_m;
  exp_t e_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   hdr_cnt  = 0;
  int   hdr0;

  i2c_addr_match #(.NUM_ADDR(2), .GEN_CALL_EN(1)) dut (
    .FPGA_clk(clk), .rst(rst_n), .SCL(scl), .SCL_prev(scl_prev), .SDA(sda),
    .enable(en), .addr_table(tbl), .addr_is10(is10), .hdr_ack(hdr_m),
    .done(done_m), .selected(sel_m), .rw(rw_m), .gen_call(gc_m),
    .is_10bit(t10_m), .match_idx(idx_m)
  );

  i2c_addr_match #(.NUM_ADDR(2), .GEN_CALL_EN(0)) dut_ngc (
    .FPGA_clk(clk), .rst(rst_n), .SCL(scl), .SCL_prev(scl_prev), .SDA(sda),
    .enable(en), .addr_table(tbl), .addr_is10(is10), .hdr_ack(hdr_n),
    .done(done_n), .selected(sel_n), .rw(rw_n), .gen_call(gc_n),
    .is_10bit(t10_n), .match_idx(idx_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) scl_prev <= scl;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic s, input logic r, input logic g, input logic t, input logic i);
    exp_t e;
    e.sel = s; e.rw = r; e.gc = g; e.t10 = t; e.idx = i;
    return e;
  endfunction

  // Scoreboard consumers: pop one expectation per done pulse.
  always @(negedge clk) begin
    if (done_m) begin
      if (q_m.size() == 0) check_val("unexp_done_m", done_m, 1'b0);
      else begin
        e_m = q_m.pop_front();
        check_val("sel_m", sel_m, e_m.sel);
        if (e_m.sel) begin
          check_val("rw_m", rw_m, e_m.rw);
          check_val("gc_m", gc_m, e_m.gc);
          check_val("t10_m", t10_m, e_m.t10);
          check_val("idx_m", idx_m, e_m.idx);
        end
      end
    end
    if (hdr_m) begin
      hdr_cnt++;
      check_val("hdr_with_done", done_m, 1'b0);
    end
    if (done_n) begin
      if (q_n.size() == 0) check_val("unexp_done_n", done_n, 1'b0);
      else begin
        e_n = q_n.pop_front();
        check_val("sel_n", sel_n, e_n.sel);
        if (e_n.sel) begin
          check_val("rw_n", rw_n, e_n.rw);
          check_val("gc_n", gc_n, e_n.gc);
          check_val("t10_n", t10_n, e_n.t10);
          check_val("idx_n", idx_n, e_n.idx);
        end
      end
    end
  end

  task automatic start_frame();
    @(negedge clk);
    en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic end_frame();
    @(negedge clk);
    scl = 1'b0;
    @(negedge clk);
    en  = 1'b0;
    scl = 1'b1;
    repeat (3) @(negedge clk);
    check_val("sel_clr", sel_m, 1'b0);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i >= 8 - n; i--) begin
      @(negedge clk);
      scl = 1'b0;
      sda = b[i];
      repeat (2) @(negedge clk);
      scl = 1'b1;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic ack_clock();
    @(negedge clk);
    scl = 1'b0;
    sda = 1'b0;
    repeat (2) @(negedge clk);
    scl = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Both scoreboards must have been drained right after the final bit.
  task automatic expect_drained();
    check_val("done_lat_m", q_m.size(), 0);
    check_val("done_lat_n", q_n.size(), 0);
  endtask

  task automatic frame1(input logic [7:0] b, input exp_t em, input exp_t en_exp);
    q_m.push_back(em);
    q_n.push_back(en_exp);
    start_frame();
    send_bits(b, 8);
    expect_drained();
    repeat (3) @(negedge clk);
    check_val("sel_hold", sel_m, em.sel);
    end_frame();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; scl = 1'b1; sda = 1'b1; en = 1'b0;
    tbl = {10'h011, 10'h03A};
    is10 = 2'b00;
    repeat (3) @(negedge clk);
    check_val("rst_outs", {hdr_m, done_m, sel_m, rw_m, gc_m, t10_m, idx_m}, 7'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 7-bit match, then async reset while selected clears outputs at once
    q_m.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    q_n.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    start_frame();
    send_bits(8'h74, 8);
    expect_drained();
    check_val("sel_before_rst", sel_m, 1'b1);
    rst_n = 1'b0;
    #1;
    check_val("rst_sel", sel_m, 1'b0);
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // duplicate slots: lowest index wins; non-matching address
    tbl = {10'h03A, 10'h03A};
    frame1(8'h75, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0), mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    frame1(8'h40, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    // general call: only the GEN_CALL_EN=1 instance responds
    frame1(8'h00, mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    frame1(8'h01, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    // 10-bit write to slot1 = 10'h2C5
    tbl  = {10'h2C5, 10'h03A};
    is10 = 2'b10;
    hdr0 = hdr_cnt;
    q_m.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
    q_n.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
    start_frame();
    send_bits(8'hF4, 8);
    check_val("hdr_ack_cnt", hdr_cnt - hdr0, 1);
    check_val("no_done_hdr", q_m.size(), 1);
    ack_clock();
    send_bits(8'hC5, 8);
    expect_drained();
    check_val("sel_10w", sel_m, 1'b1);
    end_frame();

    // repeated-start read header reuses the stored slot
    frame1(8'hF5, mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1), mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1));
    check_val("hdr_ack_total", hdr_cnt - hdr0, 1);

    // reset mid-BYTE2, then read header has no prior write match
    start_frame();
    send_bits(8'hF4, 8);
    ack_clock();
    send_bits(8'hC5, 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_b2", {hdr_m, done_m, sel_m, rw_m, gc_m, t10_m, idx_m}, 7'd0);
    @(negedge clk);
    en = 1'b0;
    scl = 1'b1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    frame1(8'hF5, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    // abort after 4 bits, then a clean frame
    start_frame();
    send_bits(8'h74, 4);
    end_frame();
    frame1(8'h74, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0), mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

    // enable drops in the same cycle as the final rise: abort wins
    start_frame();
    send_bits(8'h74, 7);
    @(negedge clk);
    scl = 1'b0;
    sda = 1'b0;
    repeat (2) @(negedge clk);
    scl = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge clk);
    check_val("abort_last_sel", sel_m, 1'b0);
    frame1(8'h74, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0), mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

    repeat (4) @(negedge clk);
    check_val("sb_empty_m", q_m.size(), 0);
    check_val("sb_empty_n", q_n.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i2c_addr_match.md
# i2c_addr_match

Parametrised I2C slave address matcher, successor to the single-address 7-bit decoder. It supports NUM_ADDR programmable slots, each in 7-bit or 10-bit mode, plus optional general-call recognition and 10-bit repeated-start read headers. It sits between the slave's START/STOP detector, which drives `enable`, and the slave byte/ACK engine, which consumes `done`, `selected`, `rw` and `match_idx`.

## Interface
Parameters:
- NUM_ADDR, 2: number of address slots, 1..8
- GEN_CALL_EN, 1: respond to general call (0000000, W)

Ports:
- FPGA_clk  in  1: system clock; all logic on its rising edge
- rst  in  1: asynchronous, active-low reset
- SCL  in  1: synchronised SCL
- SCL_prev  in  1: SCL delayed one FPGA_clk; a rising edge is SCL & !SCL_prev
- SDA  in  1: synchronised SDA
- enable  in  1: high from START (or repeated START) until STOP or next START; low aborts
- addr_table  in  NUM_ADDR*10: slot k is [10k+9:10k]; 7-bit slots use bits [6:0]
- addr_is10  in  NUM_ADDR: slot k is 10-bit when 1
- hdr_ack  out  1: one-cycle pulse; 10-bit write header matched, ACK it
- done  out  1: one-cycle pulse; address phase complete (match or no match)
- selected  out  1: level; this slave addressed; held until enable falls
- rw  out  1: captured R/W bit, valid while selected
- gen_call  out  1: match was general call, valid while selected
- is_10bit  out  1: match was 10-bit, valid while selected
- match_idx  out  $clog2(NUM_ADDR) (min 1): matching slot, valid while selected

## Operation
- Shift SDA MSB-first into an 8-bit register on each SCL rising edge while counting.
- States: IDLE, BYTE1, HDR_ACK, BYTE2, MATCHED, NOMATCH.
- IDLE -> BYTE1 when enable is high. Clear the counter and shift register.
- BYTE1 completes at the 8th rise. Byte b[7:1] is the address and b[0] is R/W. Decode:
  - b[7:1]==0, b[0]==0, GEN_CALL_EN: MATCHED, gen_call=1, match_idx=0.
  - b[7:3]==11110, b[0]==0, and some 10-bit slot has [9:8]==b[2:1]: pulse hdr_ack, go to HDR_ACK.
  - b[7:3]==11110, b[0]==1, last10_valid, and stored slot [9:8]==b[2:1]: MATCHED, rw=1, is_10bit=1, match_idx=stored slot.
  - b[7:1] equals [6:0] of a 7-bit slot: MATCHED, lowest index wins.
  - Any other value, including reserved 0000xxx/1111xxx: NOMATCH.
- HDR_ACK ignores exactly one SCL rise (the ACK clock), then goes to BYTE2.
- BYTE2 completes at the 8th rise. Match {b1[2:1], b2} against 10-bit slots, lowest index wins.
  - Match: MATCHED, rw=0, is_10bit=1, set last10_valid, store the slot index.
  - No match: NOMATCH.
- last10_valid is cleared by reset and by any completed frame that ends NOMATCH or matches a different 7-bit or 10-bit slot. A general call does not clear it.
- MATCHED and NOMATCH hold until enable falls, then go to IDLE. Further SCL edges are ignored.
- enable low in any state: go to IDLE next cycle; clear selected/rw/gen_call/is_10bit/match_idx; no done pulse.

## Timing
- Reset values: every output is 0; last10_valid is 0; state is IDLE.
- done and selected rise on the FPGA_clk edge after the cycle that sampled the final address bit (1-cycle latency). done lasts exactly one cycle.
- hdr_ack has the same 1-cycle latency after byte 1. It never coincides with done.
- A rising edge is sampled only in the cycle where SCL=1 and SCL_prev=0. Repeated START appears as enable falling for ≥1 cycle, then rising.
- If enable falls in the same cycle as the final SCL rise, abort wins: no done.
- Async reset mid-frame clears everything immediately. The first frame after reset starts fresh.

## Structure
- Shared package i2c_pkg: state enum addr_state_t, GEN_CALL_ADDR=7'h00, TENBIT_PREFIX=5'b11110, MAX_ADDR_SLOTS=8.
- Reuse the existing `counter` sub-module (WIDTH=4) for bit counting, with enable driven by the FSM and synchronous clear on state entry.
- Slot comparison is a generate loop feeding a priority encoder inside the top module.

## Test plan
- Slot0=7'h3A (7-bit): send 0x74 -> done, selected=1, rw=0, match_idx=0, is_10bit=0.
- Slot0=7'h3A, slot1=7'h3A: send 0x75 -> match_idx=0, rw=1 (priority); send 0x40 -> done, selected=0.
- GEN_CALL_EN=1: send 0x00 -> gen_call=1, selected=1. Send 0x01 -> NOMATCH. Repeat with GEN_CALL_EN=0 -> NOMATCH.
- Slot1=10'h2C5 (10-bit): send 0xF4, skip ACK rise, send 0xC5 -> hdr_ack after byte 1, then done, selected, is_10bit=1, match_idx=1. Repeated START, send 0xF5 -> selected, rw=1, match_idx=1.
- 10-bit read header 0xF5 with no prior 10-bit write match after reset -> done, selected=0.
- Drop enable after 4 bits of 0x74, then re-enable and send 0x74 -> no done for the aborted frame, normal match after. Assert rst mid-BYTE2 -> all outputs 0 immediately.
